gpu_top_check: RTL and testbench

Top-level checking shell for the GPU front end. Holds four FileIO-loadable stores:
- task-manager (TM) warp table
- 4096-word instruction cache
- 512 x 256-bit data memory (main + shared)
- 256-entry cache-latency table

On start, a run FSM walks the valid warp entries and fetches each warp's instruction stream until an EXIT word, then raises finished.

---
 rtl/gpu_check_pkg.sv | 12 +
 rtl/gpu_check_icache.sv | 37 +++
 rtl/gpu_top_check.sv | 225 ++++++++++++++++++++++
 tb/tb_gpu_top_check.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_check_pkg.sv
// Shared constants and types for the gpu_top_check shell.
package gpu_check_pkg;
  localparam logic [31:0] EXIT_OP   = 32'hFFFF_FFFF;
  localparam int          VALID_BIT = 28;
  localparam int          PC_MSB    = 11;
  localparam int          TM_DEPTH  = 8;
  localparam int          TM_IDX_W  = $clog2(TM_DEPTH);
  // One extra bit so the pointer can hold TM_DEPTH (table full).
  localparam int          TM_PTR_W  = TM_IDX_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} run_state_e;
endpackage

// File: rtl/gpu_check_icache.sv
// 4096x32 instruction cache: FileIO read/write port plus fetch read port,
// both with registered (1-cycle) read data, read-before-write.
module gpu_check_icache
  import gpu_check_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fio_wen_i,
  input  logic [PC_MSB:0] fio_addr_i,
  input  logic [31:0]     fio_din_i,
  output logic [31:0]     fio_dout_o,
  input  logic [PC_MSB:0] fetch_addr_i,
  output logic [31:0]     fetch_dout_o
);
  logic [31:0] mem_q [2**(PC_MSB+1)];
  logic [31:0] fio_dout_q;
  logic [31:0] fetch_dout_q;

  // Storage write from the FileIO port; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (fio_wen_i) mem_q[fio_addr_i] <= fio_din_i;
  end

  // Registered reads on both ports; output registers clear on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fio_dout_q   <= '0;
      fetch_dout_q <= '0;
    end else begin
      fio_dout_q   <= mem_q[fio_addr_i];
      fetch_dout_q <= mem_q[fetch_addr_i];
    end
  end

  assign fio_dout_o   = fio_dout_q;
  assign fetch_dout_o = fetch_dout_q;
endmodule

// File: rtl/gpu_top_check.sv
// GPU front-end checking shell: TM warp table, ICache, data memory,
// latency table and the warp-run FSM.
// Optional macro GPU_TOP_CHECK_TIMEOUT_EN: caps each warp at 4096 fetches.
module gpu_top_check
  import gpu_check_pkg::*;
#(
  parameter  int mem_size       = 256,
  parameter  int shmem_size     = 256,
  localparam int addr_width     = $clog2(mem_size + shmem_size),
  localparam int mem_addr_width = $clog2(mem_size)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Write_Enable_FIO_TM,
  input  logic [28:0]               Write_Data_FIO_TM,
  input  logic                      start_FIO_TM,
  input  logic                      clear_FIO_TM,
  output logic                      finished_TM_FIO,
  input  logic                      FileIO_Wen_ICache,
  input  logic [11:0]               FileIO_Addr_ICache,
  input  logic [31:0]               FileIO_Din_ICache,
  output logic [31:0]               FileIO_Dout_ICache,
  input  logic                      FIO_MEMWRITE,
  input  logic [addr_width-1:0]     FIO_ADDR,
  input  logic [255:0]              FIO_WRITE_DATA,
  output logic [255:0]              FIO_READ_DATA,
  input  logic                      FIO_CACHE_LAT_WRITE,
  input  logic [4:0]                FIO_CACHE_LAT_VALUE,
  input  logic [mem_addr_width-1:0] FIO_CACHE_MEM_ADDR
);
  run_state_e            state_q, state_d;
  logic [TM_PTR_W-1:0]   wptr_q, wptr_d;
  logic [TM_DEPTH-1:0]   valid_q, valid_d;
  logic [TM_DEPTH-1:0]   done_q, done_d;
  logic [PC_MSB:0]       pc_q, pc_d;
  logic [TM_IDX_W-1:0]   cur_q, cur_d;
  logic                  pend_q, pend_d;
  logic                  fin_q, fin_d;
  logic                  tm_we;
  logic [PC_MSB:0]       tm_pc_q [TM_DEPTH];
  logic                  sel_found;
  logic [TM_IDX_W-1:0]   sel_idx;
  logic                  warp_end;
  logic [31:0]           fetch_word;
  logic [255:0]          dm_q [mem_size + shmem_size];
  logic [255:0]          rd1_q, rd2_q;
  logic [4:0]            lat_q [mem_size];
`ifdef GPU_TOP_CHECK_TIMEOUT_EN
  logic [PC_MSB:0]       cnt_q, cnt_d;
  logic                  tout_q, tout_d;
`endif

  gpu_check_icache u_icache (
    .clk_i        (clk),
    .rst_i        (rst),
    .fio_wen_i    (FileIO_Wen_ICache),
    .fio_addr_i   (FileIO_Addr_ICache),
    .fio_din_i    (FileIO_Din_ICache),
    .fio_dout_o   (FileIO_Dout_ICache),
    .fetch_addr_i (pc_q),
    .fetch_dout_o (fetch_word)
  );

  // Lowest-index valid entry that has not yet been run.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < TM_DEPTH; i++) begin
      if (!sel_found && valid_q[i] && !done_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = TM_IDX_W'(i);
      end
    end
  end

  // Next-state logic for the run FSM and TM bookkeeping.
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    valid_d  = valid_q;
    done_d   = done_q;
    pc_d     = pc_q;
    cur_d    = cur_q;
    pend_d   = 1'b0;
    fin_d    = fin_q;
    tm_we    = 1'b0;
    warp_end = 1'b0;
`ifdef GPU_TOP_CHECK_TIMEOUT_EN
    cnt_d    = cnt_q;
    tout_d   = tout_q;
`endif
    case (state_q)
      IDLE: begin
        if (clear_FIO_TM) begin
          valid_d = '0;
          wptr_d  = '0;
          fin_d   = 1'b0;
`ifdef GPU_TOP_CHECK_TIMEOUT_EN
          tout_d  = 1'b0;
`endif
        end else begin
          if (Write_Enable_FIO_TM && (wptr_q < TM_PTR_W'(TM_DEPTH))) begin
            tm_we   = 1'b1;
            valid_d[wptr_q[TM_IDX_W-1:0]] = Write_Data_FIO_TM[VALID_BIT];
            wptr_d  = wptr_q + TM_PTR_W'(1);
          end
          if (start_FIO_TM) begin
            state_d = SCAN;
            done_d  = '0;
          end
        end
      end
      SCAN: begin
        if (sel_found) begin
          pc_d    = tm_pc_q[sel_idx];
          cur_d   = sel_idx;
          state_d = FETCH;
`ifdef GPU_TOP_CHECK_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = DONE;
          fin_d   = 1'b1;
        end
      end
      FETCH: begin
        // A read is issued every cycle; pend_q marks that fetch_word holds
        // the word for the previous cycle's pc.
        pend_d = 1'b1;
        pc_d   = pc_q + 12'd1;
        if (pend_q) begin
          warp_end = (fetch_word == EXIT_OP);
`ifdef GPU_TOP_CHECK_TIMEOUT_EN
          cnt_d = cnt_q + 12'd1;
          if (!warp_end && (cnt_q == '1)) begin
            warp_end = 1'b1;
            tout_d   = 1'b1;
          end
`endif
          if (warp_end) begin
            done_d[cur_q] = 1'b1;
            state_d       = SCAN;
            pend_d        = 1'b0;
          end
        end
      end
      DONE: begin
        if (clear_FIO_TM) begin
          valid_d = '0;
          wptr_d  = '0;
          fin_d   = 1'b0;
          state_d = IDLE;
`ifdef GPU_TOP_CHECK_TIMEOUT_EN
          tout_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Run FSM and TM control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
      pc_q    <= '0;
      cur_q   <= '0;
      pend_q  <= 1'b0;
      fin_q   <= 1'b0;
`ifdef GPU_TOP_CHECK_TIMEOUT_EN
      cnt_q   <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      pc_q    <= pc_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      fin_q   <= fin_d;
`ifdef GPU_TOP_CHECK_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
`endif
    end
  end

  // TM start-PC storage (valid bits live in valid_q).
  always_ff @(posedge clk) begin
    if (tm_we) tm_pc_q[wptr_q[TM_IDX_W-1:0]] <= Write_Data_FIO_TM[PC_MSB:0];
  end

  // Data memory and latency table storage; contents are never reset.
  always_ff @(posedge clk) begin
    if (FIO_MEMWRITE) dm_q[FIO_ADDR] <= FIO_WRITE_DATA;
    if (FIO_CACHE_LAT_WRITE) lat_q[FIO_CACHE_MEM_ADDR] <= FIO_CACHE_LAT_VALUE;
  end

  // Two-stage registered data-memory read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= dm_q[FIO_ADDR];
      rd2_q <= rd1_q;
    end
  end

  assign FIO_READ_DATA   = rd2_q;
  assign finished_TM_FIO = fin_q;

  // Stored-but-unread state kept visible to avoid dangling logic.
  logic unused_bits;
`ifdef GPU_TOP_CHECK_TIMEOUT_EN
  assign unused_bits = ^{Write_Data_FIO_TM[27:12], lat_q[0], tout_q};
`else
  assign unused_bits = ^{Write_Data_FIO_TM[27:12], lat_q[0]};
`endif
endmodule

// File: tb/tb_gpu_top_check.sv
// Self-checking bench for gpu_top_check.
module tb_gpu_top_check;
  localparam logic [31:0] EXIT_W = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst, tm_we, start, clear, finished;
  logic [28:0]  tm_wd;
  logic         ic_wen;
  logic [11:0]  ic_addr;
  logic [31:0]  ic_din, ic_dout;
  logic         mw;
  logic [8:0]   maddr;
  logic [255:0] mwd, mrd;
  logic         lw;
  logic [4:0]   lv;
  logic [7:0]   la;

  int checks = 0;
  int errors = 0;

  logic [31:0]  ic_m [4096];
  logic [255:0] dm_m [512];
  logic [28:0]  tm_m [$];
  logic [255:0] rd_pend [$];

  typedef struct {
    logic        wen;
    logic [11:0] addr;
    logic [31:0] din;
    logic        chk;
    logic [31:0] exp;
  } icv_t;
  icv_t icv [7];

  always #5 clk = ~clk;

  gpu_top_check dut (
    .clk                 (clk),
    .rst                 (rst),
    .Write_Enable_FIO_TM (tm_we),
    .Write_Data_FIO_TM   (tm_wd),
    .start_FIO_TM        (start),
    .clear_FIO_TM        (clear),
    .finished_TM_FIO     (finished),
    .FileIO_Wen_ICache   (ic_wen),
    .FileIO_Addr_ICache  (ic_addr),
    .FileIO_Din_ICache   (ic_din),
    .FileIO_Dout_ICache  (ic_dout),
    .FIO_MEMWRITE        (mw),
    .FIO_ADDR            (maddr),
    .FIO_WRITE_DATA      (mwd),
    .FIO_READ_DATA       (mrd),
    .FIO_CACHE_LAT_WRITE (lw),
    .FIO_CACHE_LAT_VALUE (lv),
    .FIO_CACHE_MEM_ADDR  (la)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_int(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic chk256(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == EXIT_W) w = 32'h0;
    return w;
  endfunction

  task automatic ic_write(input logic [11:0] a, input logic [31:0] d);
    ic_wen = 1'b1; ic_addr = a; ic_din = d;
    tick();
    ic_wen = 1'b0;
    ic_m[a] = d;
  endtask

  // Table accepts appends only while fewer than 8 entries are held.
  task automatic tm_write(input logic [28:0] e);
    tm_we = 1'b1; tm_wd = e;
    tick();
    tm_we = 1'b0;
    if (tm_m.size() < 8) tm_m.push_back(e);
  endtask

  task automatic tm_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tm_m.delete();
  endtask

  // Start-to-finished latency: 2 cycles of scan overhead, plus for each
  // valid warp (in index order) one cycle to enter fetch, one cycle of
  // read latency and one cycle per fetched word up to and including EXIT.
  function automatic int exp_cycles();
    int total;
    int n;
    int limit;
    logic [11:0] pc;
`ifdef GPU_TOP_CHECK_TIMEOUT_EN
    limit = 4096;
`else
    limit = 5000;
`endif
    total = 2;
    foreach (tm_m[i]) begin
      if (tm_m[i][28]) begin
        pc = tm_m[i][11:0];
        n  = 1;
        while (ic_m[pc] != EXIT_W && n < limit) begin
          pc = pc + 12'd1;
          n++;
        end
        total += n + 2;
      end
    end
    return total;
  endfunction

  task automatic run_check(input string nm, input bit inject);
    int exp_n;
    int n;
    exp_n = exp_cycles();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!finished && n < exp_n + 100) begin
      tm_we = inject && (n == 3);
      tm_wd = {1'b1, 16'h0, 12'd100};
      tick();
      n++;
    end
    tm_we = 1'b0;
    chk_int({nm, " cycles"}, n, exp_n);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    chk_int({nm, " finished held"}, int'(finished), 1);
    tm_clear();
    chk_int({nm, " finished cleared"}, int'(finished), 0);
  endtask

  initial begin
    rst = 1'b1; tm_we = 1'b0; tm_wd = '0; start = 1'b0; clear = 1'b0;
    ic_wen = 1'b0; ic_addr = '0; ic_din = '0;
    mw = 1'b0; maddr = '0; mwd = '0; lw = 1'b0; lv = '0; la = '0;
    tick(); tick();
    rst = 1'b0;
    chk_int("reset finished", int'(finished), 0);
    chk32("reset icache dout", ic_dout, 32'h0);
    chk256("reset read data", mrd, '0);

    // Known ICache contents, no EXIT words.
    for (int i = 0; i < 4096; i++) ic_write(12'(i), rnd_word());

    // Directed ICache vectors.
    icv[0] = '{1'b1, 12'd5, 32'h0000_0042, 1'b0, 32'h0};
    icv[1] = '{1'b0, 12'd5, 32'h0,         1'b1, 32'h0000_0042};
    icv[2] = '{1'b1, 12'd5, 32'h0000_0099, 1'b1, 32'h0000_0042};
    icv[3] = '{1'b0, 12'd5, 32'h0,         1'b1, 32'h0000_0099};
    icv[4] = '{1'b1, 12'd6, 32'h0000_0077, 1'b0, 32'h0};
    icv[5] = '{1'b0, 12'd6, 32'h0,         1'b1, 32'h0000_0077};
    icv[6] = '{1'b0, 12'd5, 32'h0,         1'b1, 32'h0000_0099};
    for (int i = 0; i < 7; i++) begin
      ic_wen = icv[i].wen; ic_addr = icv[i].addr; ic_din = icv[i].din;
      tick();
      if (icv[i].chk) chk32("icache vector", ic_dout, icv[i].exp);
      if (icv[i].wen) ic_m[icv[i].addr] = icv[i].din;
    end
    ic_wen = 1'b0;

    // Random ICache traffic on a narrow address window.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] e;
      ic_addr = 12'($urandom_range(0, 31));
      ic_wen  = 1'($urandom_range(0, 1));
      ic_din  = rnd_word();
      e = ic_m[ic_addr];
      tick();
      chk32("icache random", ic_dout, e);
      if (ic_wen) ic_m[ic_addr] = ic_din;
    end
    ic_wen = 1'b0;

    // Data memory fill: main lines get {8{i}}, shared lines random.
    for (int i = 0; i < 512; i++) begin
      mw = 1'b1; maddr = 9'(i);
      if (i < 256) mwd = {8{32'(i)}};
      else mwd = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
      dm_m[i] = mwd;
      tick();
    end
    mw = 1'b0;
    maddr = 9'd10; tick(); tick();
    maddr = 9'd3;  tick();
    chk256("mem read 1 cycle", mrd, {8{32'd10}});
    tick();
    chk256("mem read 2 cycles", mrd, {8{32'd3}});
    mw = 1'b1; maddr = 9'd300; mwd = {8{32'hA5A5_0300}}; tick();
    mw = 1'b0; dm_m[300] = mwd;
    tick(); tick();
    chk256("mem shared 300", mrd, {8{32'hA5A5_0300}});
    maddr = 9'd44; tick(); tick();
    chk256("mem addr 44", mrd, {8{32'd44}});

    // Random data memory traffic against a two-deep read queue.
    rd_pend.delete();
    for (int i = 0; i < 300; i++) begin
      maddr = 9'($urandom_range(0, 511));
      mw    = 1'($urandom_range(0, 1));
      mwd   = {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
      rd_pend.push_back(dm_m[maddr]);
      if (mw) dm_m[maddr] = mwd;
      tick();
      if (rd_pend.size() >= 2) chk256("mem random", mrd, rd_pend.pop_front());
    end
    mw = 1'b0;

    // Latency table writes (storage only), including index 256 wrapping.
    begin
      logic [8:0] idx9;
      idx9 = 9'd256;
      lw = 1'b1; la = idx9[7:0]; lv = 5'd7; tick();
      la = 8'd255; lv = 5'd3; tick();
      lw = 1'b0;
    end

    // Single warp at PC 10: 1, 2, EXIT.
    tm_clear();
    ic_write(12'd10, 32'h1); ic_write(12'd11, 32'h2); ic_write(12'd12, EXIT_W);
    tm_write({1'b1, 16'h0, 12'd10});
    run_check("one warp", 1'b0);

    // Two valid warps around one invalid entry.
    ic_write(12'd0, 32'h5); ic_write(12'd1, 32'h6); ic_write(12'd2, EXIT_W);
    ic_write(12'd100, EXIT_W);
    tm_write({1'b1, 16'h1234, 12'd0});
    tm_write({1'b0, 16'h0,    12'd50});
    tm_write({1'b1, 16'h0,    12'd100});
    run_check("two warps", 1'b0);

    // Nine writes: the ninth (long warp) must be dropped.
    for (int i = 0; i < 8; i++) tm_write({1'b1, 16'h0, 12'd100});
    tm_write({1'b1, 16'h0, 12'd10});
    run_check("nine writes", 1'b0);

    // Writes while running are ignored.
    tm_write({1'b1, 16'h0, 12'd10});
    run_check("write while busy", 1'b1);

    // Zero valid entries.
    tm_write({1'b0, 16'h0, 12'd10});
    tm_write({1'b0, 16'h0, 12'd100});
    run_check("no valid", 1'b0);

    // Clear wins over a same-cycle TM write.
    tm_write({1'b1, 16'h0, 12'd10});
    clear = 1'b1; tm_we = 1'b1; tm_wd = {1'b1, 16'h0, 12'd100};
    tick();
    clear = 1'b0; tm_we = 1'b0; tm_m.delete();
    run_check("clear priority", 1'b0);

    // Reset during FETCH aborts the run.
    ic_write(12'd215, EXIT_W);
    tm_write({1'b1, 16'h0, 12'd200});
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    tm_m.delete();
    chk_int("reset mid-run finished", int'(finished), 0);
    chk32("reset mid-run icache dout", ic_dout, 32'h0);
    run_check("after reset", 1'b0);

    // Randomized warp tables.
    for (int r = 0; r < 6; r++) begin
      int k;
      int len;
      logic [11:0] pc;
      logic v;
      k = $urandom_range(0, 8);
      for (int e = 0; e < k; e++) begin
        pc  = 12'($urandom_range(0, 4095));
        len = $urandom_range(0, 15);
        v   = ($urandom_range(0, 3) != 0);
        if (v) ic_write(pc + 12'(len), EXIT_W);
        tm_write({v, 16'($urandom), pc});
      end
      run_check("random run", 1'b0);
    end

`ifdef GPU_TOP_CHECK_TIMEOUT_EN
    for (int i = 0; i < 4096; i++) ic_write(12'(i), rnd_word());
    tm_write({1'b1, 16'h0, 12'd7});
    run_check("timeout warp", 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
